eight_bit_serial_subtractor: RTL and testbench

EIGHT_BIT_SERIAL_SUBTRACTOR -- requirements
Module: eight_bit_serial_subtractor

---
 rtl/eight_bit_serial_subtractor_pkg.sv | 20 ++
 rtl/eight_bit_serial_subtractor_full_subtractor.sv | 20 ++
 rtl/eight_bit_serial_subtractor.sv | 109 ++++++++++
 tb/tb_eight_bit_serial_subtractor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/eight_bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width.
//   state_t       : control FSM encoding (IDLE, SHIFT, DONE).
//   cnt_width()   : width of the bit counter for a given operand width.
package eight_bit_serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // One extra bit over $clog2 so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/eight_bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: computes a - b - bin.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // A borrow is produced when b exceeds a, or when the bits are equal
  // and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), one bit per clock, LSB first.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, honoured only in IDLE
//   a, b   : minuend / subtrahend, captured on the accepted start cycle
//   diff   : registered result, updated once per operation
//   bout   : registered final borrow (a < b unsigned)
//   busy   : high from the cycle after accept through the last shift cycle
//   done   : one-cycle pulse when diff/bout are updated
// Timing: start accepted at edge N -> done high after edge N+WIDTH+1.
module eight_bit_serial_subtractor
  import eight_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             brw_next;

  // The only arithmetic in the datapath: one bit per cycle from the
  // low end of the operand shift registers.
  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (brw_next)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain shifts within
  // one edge and break the serial ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          // Result fills from the MSB side, so after WIDTH shifts the
          // first (LSB) difference bit has reached bit 0.
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          brw    <= brw_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          diff  <= res_sr;
          bout  <= brw;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Self-checking bench for eight_bit_serial_subtractor (WIDTH = 8).
// Directed table of operand pairs, hand-written corner sequences
// (ignored start while busy, mid-operation reset), then a back-to-back
// stream with start held high checked against plain-arithmetic expectations.
module tb_eight_bit_serial_subtractor;

  localparam int W    = 8;
  localparam int LAT  = W + 1;   // posedges from accept edge to done-visible edge
  localparam int NOPS = 400;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc       = 0;

  eight_bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Runs one operation from a negedge; scrambles a/b after accept.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] rd, output logic rb,
                        output int lat, output int busy_cycles,
                        output int overlap, output int diff_changes);
    logic [W-1:0] prev;
    prev         = diff;
    lat          = 0;
    busy_cycles  = 0;
    overlap      = 0;
    diff_changes = 0;
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      if (busy) busy_cycles++;
      if (busy && done) overlap++;
      if (done) break;
      if (diff !== prev) diff_changes++;
      if (lat > 40) break;
      @(posedge clk);
      lat++;
    end
    rd = diff;
    rb = bout;
  endtask

  vec_t  tbl[7];
  pair_t corners[6];
  pair_t q[$];

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    int           lat, bcyc, ovl, dchg, n_done, got, issued, last_done;
    logic [W-1:0] d1;
    logic         b1;
    pair_t        p, e;

    tbl = '{
      '{a: 8'd200, b: 8'd55,  diff: 8'd145, bout: 1'b0},
      '{a: 8'd5,   b: 8'd10,  diff: 8'd251, bout: 1'b1},
      '{a: 8'd0,   b: 8'd0,   diff: 8'd0,   bout: 1'b0},
      '{a: 8'd255, b: 8'd255, diff: 8'd0,   bout: 1'b0},
      '{a: 8'd0,   b: 8'd1,   diff: 8'd255, bout: 1'b1},
      '{a: 8'd255, b: 8'd0,   diff: 8'd255, bout: 1'b0},
      '{a: 8'd128, b: 8'd129, diff: 8'd255, bout: 1'b1}
    };
    corners = '{
      '{a: 8'd0,   b: 8'd0},
      '{a: 8'd255, b: 8'd255},
      '{a: 8'd0,   b: 8'd255},
      '{a: 8'd255, b: 8'd0},
      '{a: 8'd128, b: 8'd127},
      '{a: 8'd127, b: 8'd128}
    };

    // Reset state.
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_diff", int'(diff), 0);
    check("reset_flags", int'({bout, busy, done}), 0);
    rst_n = 1'b1;

    // Directed table; the first entry starts right after reset release.
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, rd, rb, lat, bcyc, ovl, dchg);
      check($sformatf("tbl%0d_diff", i), int'(rd), int'(tbl[i].diff));
      check($sformatf("tbl%0d_bout", i), int'(rb), int'(tbl[i].bout));
      check($sformatf("tbl%0d_latency", i), lat, LAT);
      check($sformatf("tbl%0d_busy_cycles", i), bcyc, W);
      check($sformatf("tbl%0d_busy_done_overlap", i), ovl, 0);
      check($sformatf("tbl%0d_diff_stable", i), dchg, 0);
      @(negedge clk);
      check($sformatf("tbl%0d_done_single", i), int'(done), 0);
    end

    // Start while busy is ignored and not queued.
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd1;
    @(posedge clk);
    n_done = 0;
    d1     = '0;
    b1     = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start = (k == 3);
      a     = (k == 3) ? 8'd7 : W'($urandom);
      b     = (k == 3) ? 8'd9 : W'($urandom);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          d1 = diff;
          b1 = bout;
        end
      end
    end
    check("busy_start_done_count", n_done, 1);
    check("busy_start_diff", int'(d1), 99);
    check("busy_start_bout", int'(b1), 0);

    // Reset in the middle of an operation.
    start = 1'b1;
    a     = 8'd77;
    b     = 8'd33;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midreset_diff", int'(diff), 0);
    check("midreset_flags", int'({bout, busy, done}), 0);
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done) n_done++;
    end
    check("midreset_no_done", n_done, 0);
    run_op(8'd77, 8'd33, rd, rb, lat, bcyc, ovl, dchg);
    check("restart_diff", int'(rd), 44);
    check("restart_latency", lat, LAT);

    // Fresh reset, then back-to-back stream with start held high.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p = corners[0];
    q.push_back(p);
    issued    = 1;
    got       = 0;
    last_done = 0;
    start     = 1'b1;
    a         = p.a;
    b         = p.b;
    for (int t = 0; t < NOPS * 12 + 100 && got < NOPS; t++) begin
      @(negedge clk);
      if (done) begin
        e = q.pop_front();
        check("stream_diff", int'(diff), int'(W'(e.a - e.b)));
        check("stream_bout", int'(bout), int'(e.a < e.b));
        check("stream_busy_low", int'(busy), 0);
        if (got > 0) check("stream_spacing", cyc - last_done, W + 2);
        last_done = cyc;
        got++;
        if (issued < NOPS) begin
          if (issued < 6) p = corners[issued];
          else begin
            p.a = W'($urandom);
            p.b = W'($urandom);
          end
          q.push_back(p);
          issued++;
          a = p.a;
          b = p.b;
        end else begin
          start = 1'b0;
        end
      end else begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    check("stream_count", got, NOPS);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
